// File: rtl/fetch_pkg.sv
// Shared defaults and state encoding for the instruction fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W_DEF     = 72;
  localparam int INSTR_W_DEF    = 72;
  localparam int IMEM_DEPTH_DEF = 1024;
  localparam int RESET_PC_DEF   = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry valid/ready buffer (output register + skid slot) with a flush that
// drops everything buffered; the skid always drains ahead of newer input.
module fetch_skid_buffer #(
  parameter int DATA_W = 144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              skid_valid
);

  logic [DATA_W-1:0] skid_data;
  logic              out_free;
  logic              load_skid;

  assign out_free  = !out_valid || out_ready;
  assign load_skid = in_valid && !flush && (skid_valid || !out_free);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= in_valid;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: skid_data is pure datapath qualified by skid_valid, so it carries no
  // reset; only the control bits need a known value.
  always_ff @(posedge clk) begin
    if (load_skid) skid_data <= in_data;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one synchronous imem read per
// cycle, tracks the 1-cycle return and presents {instr, pc} to decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                INSTR_W    = INSTR_W_DEF,
  parameter int                IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               busy,
  output logic               fault
);

  localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(IMEM_DEPTH);

  fetch_state_t        state, state_d;
  logic [ADDR_W-1:0]   pc, pc_d;
  logic                inflight, inflight_d;
  logic [ADDR_W-1:0]   inflight_pc, inflight_pc_d;
  logic                flush;
  logic                skid_valid;
  logic                push;
  logic [1:0]          occ, occ_eff;
  logic                can_issue;

  // occ_eff is what will still be held once this cycle's handshake retires.
  assign occ       = {1'b0, inflight} + {1'b0, out_valid} + {1'b0, skid_valid};
  assign occ_eff   = occ - {1'b0, out_valid & out_ready};
  assign can_issue = occ_eff < 2'd2;

  // A return coinciding with a redirect belongs to the old path and is dropped.
  assign push  = inflight && !redirect_valid;
  assign busy  = inflight | out_valid | skid_valid;
  assign fault = (state == FAULT);

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc;
    imem_en       = 1'b0;
    imem_addr     = pc;
    flush         = 1'b0;

    if (redirect_valid) begin
      flush     = 1'b1;
      imem_addr = redirect_pc;
      imem_en   = fetch_en && (redirect_pc < DEPTH_LIMIT);
      state_d   = fetch_en ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE:  if (fetch_en) state_d = RUN;
        RUN: begin
          if (!fetch_en) begin
            state_d = (occ != 2'd0) ? DRAIN : IDLE;
          end else if (can_issue) begin
            if (pc < DEPTH_LIMIT) imem_en = 1'b1;
            else                  state_d = FAULT;
          end
        end
        DRAIN: begin
          if (fetch_en)            state_d = RUN;
          else if (occ == 2'd0)    state_d = IDLE;
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end

    if (imem_en) begin
      pc_d          = imem_addr + ADDR_W'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = imem_addr;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      inflight    <= inflight_d;
      inflight_pc <= inflight_pc_d;
    end
  end

  fetch_skid_buffer #(
    .DATA_W(INSTR_W + ADDR_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (push),
    .in_data   ({imem_rdata, inflight_pc}),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  ({out_instr, out_pc}),
    .skid_valid(skid_valid)
  );

endmodule
